// File: rtl/rect_fill.sv
// Rectangle rasteriser: walks a clamped rectangle one pixel per clock, either
// filled in raster order or as an outline, and pulses done when finished.
module rect_fill #(
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int COLOR_W = 3,
  parameter int H_RES   = 320,
  parameter int V_RES   = 240
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [X_W-1:0]     x0,
  input  logic [X_W-1:0]     x1,
  input  logic [Y_W-1:0]     y0,
  input  logic [Y_W-1:0]     y1,
  input  logic [COLOR_W-1:0] color_in,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [COLOR_W-1:0] color,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

  state_t state, state_next;

  logic [X_W-1:0] x_start, x_end;
  logic [Y_W-1:0] y_start, y_end;
  logic           outline;

  logic [X_W-1:0] x1_clamp;
  logic [Y_W-1:0] y1_clamp;
  logic           empty;

  logic           row_end, edge_row, last_pix;
  logic [X_W-1:0] x_next;
  logic [Y_W-1:0] y_next;

  // Bounds are clamped before latching so traversal never leaves the screen.
  assign x1_clamp = (x1 > X_MAX) ? X_MAX : x1;
  assign y1_clamp = (y1 > Y_MAX) ? Y_MAX : y1;
  assign empty    = (x0 > x1_clamp) || (y0 > y1_clamp) || (x0 > X_MAX) || (y0 > Y_MAX);

  // Interior outline rows visit only x_start then x_end; x_start==x_end ends the row at once.
  always_comb begin
    row_end  = (x == x_end);
    edge_row = (y == y_start) || (y == y_end);
    last_pix = row_end && (y == y_end);
    x_next   = x + 1'b1;
    y_next   = y;
    if (row_end) begin
      x_next = x_start;
      y_next = y + 1'b1;
    end else if (outline && !edge_row) begin
      x_next = x_end;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = empty ? DONE : DRAW;
        end
      end
      DRAW: begin
        if (abort) begin
          state_next = IDLE;
        end else if (last_pix) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    plot = (state == DRAW);
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x       <= '0;
      y       <= '0;
      color   <= '0;
      x_start <= '0;
      x_end   <= '0;
      y_start <= '0;
      y_end   <= '0;
      outline <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        x_start <= x0;
        x_end   <= x1_clamp;
        y_start <= y0;
        y_end   <= y1_clamp;
        outline <= mode;
        // An empty rectangle leaves the pixel outputs at their previous values.
        if (!empty) begin
          x     <= x0;
          y     <= y0;
          color <= color_in;
        end
      end else if (state == DRAW && !abort && !last_pix) begin
        x <= x_next;
        y <= y_next;
      end
    end
  end

endmodule

// File: tb/tb_rect_fill.sv
// Bench for rect_fill: directed corner cases plus random rectangles compared
// against a pixel list built by scanning the rectangle's bounding box.
module tb_rect_fill;

  localparam int H = 320;
  localparam int V = 240;

  logic       clock, resetn, start, abort, mode;
  logic [8:0] x0, x1, x;
  logic [7:0] y0, y1, y;
  logic [2:0] color_in, color;
  logic       plot, busy, done;

  int passed, total;
  int ex_q[$], ey_q[$];
  int last_x, last_y, last_c;

  rect_fill dut (
    .clock(clock), .resetn(resetn), .start(start), .abort(abort), .mode(mode),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color_in(color_in),
    .x(x), .y(y), .color(color), .plot(plot), .busy(busy), .done(done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pk(input logic p, input logic b, input logic d,
                                     input int xx, input int yy, input int cc);
    return {9'b0, p, b, d, 9'(xx), 8'(yy), 3'(cc)};
  endfunction

  function automatic logic [31:0] obs();
    return pk(plot, busy, done, int'(x), int'(y), int'(color));
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Reference: every pixel of the clamped box, kept if filling or on the border.
  task automatic build(input logic m, input logic [8:0] a0, input logic [8:0] a1,
                       input logic [7:0] b0, input logic [7:0] b1);
    int cx1, cy1;
    cx1 = (int'(a1) > H - 1) ? H - 1 : int'(a1);
    cy1 = (int'(b1) > V - 1) ? V - 1 : int'(b1);
    ex_q.delete();
    ey_q.delete();
    for (int yy = int'(b0); yy <= cy1; yy++)
      for (int xx = int'(a0); xx <= cx1; xx++)
        if (!m || yy == int'(b0) || yy == cy1 || xx == int'(a0) || xx == cx1) begin
          ex_q.push_back(xx);
          ey_q.push_back(yy);
        end
  endtask

  task automatic scramble();
    x0 = 9'($urandom); x1 = 9'($urandom);
    y0 = 8'($urandom); y1 = 8'($urandom);
    mode = 1'($urandom); color_in = 3'($urandom);
  endtask

  task automatic draw(input logic m, input logic [8:0] a0, input logic [8:0] a1,
                      input logic [7:0] b0, input logic [7:0] b1, input logic [2:0] c,
                      input bit ds, input bit ai, input string tag);
    build(m, a0, a1, b0, b1);
    mode = m; x0 = a0; x1 = a1; y0 = b0; y1 = b1; color_in = c;
    start = 1'b1;
    abort = ai;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    scramble();
    foreach (ex_q[i]) begin
      chk({tag, "_pix"}, obs(), pk(1'b1, 1'b1, 1'b0, ex_q[i], ey_q[i], int'(c)));
      last_x = ex_q[i]; last_y = ey_q[i]; last_c = int'(c);
      @(negedge clock);
    end
    chk({tag, "_done"}, obs(), pk(1'b0, 1'b1, 1'b1, last_x, last_y, last_c));
    if (ds) start = 1'b1;
    @(negedge clock);
    chk({tag, "_idle"}, obs(), pk(1'b0, 1'b0, 1'b0, last_x, last_y, last_c));
  endtask

  initial begin
    passed = 0; total = 0;
    last_x = 0; last_y = 0; last_c = 0;
    resetn = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; color_in = '0;
    #2 resetn = 1'b0;
    #1 chk("reset_async", obs(), pk(1'b0, 1'b0, 1'b0, 0, 0, 0));
    repeat (2) @(negedge clock);
    chk("reset_hold", obs(), pk(1'b0, 1'b0, 1'b0, 0, 0, 0));
    resetn = 1'b1;

    draw(1'b0, 9'd120, 9'd122, 8'd5, 8'd6, 3'd7, 1'b0, 1'b0, "fill_small");
    draw(1'b1, 9'd10, 9'd13, 8'd0, 8'd3, 3'd5, 1'b0, 1'b0, "outline_4x4");
    draw(1'b0, 9'd318, 9'd400, 8'd239, 8'd250, 3'd2, 1'b0, 1'b0, "clamp");
    draw(1'b0, 9'd50, 9'd40, 8'd5, 8'd5, 3'd1, 1'b0, 1'b0, "empty_x");
    draw(1'b1, 9'd330, 9'd335, 8'd3, 8'd4, 3'd6, 1'b0, 1'b0, "empty_x0");
    draw(1'b1, 9'd7, 9'd7, 8'd2, 8'd6, 3'd3, 1'b0, 1'b0, "outline_col");
    draw(1'b1, 9'd300, 9'd319, 8'd230, 8'd239, 3'd4, 1'b1, 1'b0, "corner_ol");
    draw(1'b0, 9'd317, 9'd319, 8'd237, 8'd239, 3'd6, 1'b1, 1'b0, "corner_fill");
    draw(1'b0, 9'd0, 9'd1, 8'd0, 8'd1, 3'd1, 1'b0, 1'b1, "abort_idle");

    // Abort on the third pixel of a 10x10 fill while start stays high.
    build(1'b0, 9'd0, 9'd9, 8'd0, 8'd9);
    mode = 1'b0; x0 = 9'd0; x1 = 9'd9; y0 = 8'd0; y1 = 8'd9; color_in = 3'd5;
    start = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      chk("abort_pix", obs(), pk(1'b1, 1'b1, 1'b0, ex_q[i], ey_q[i], 5));
      last_x = ex_q[i]; last_y = ey_q[i]; last_c = 5;
      if (i == 2) abort = 1'b1;
      @(negedge clock);
    end
    chk("abort_stop", obs(), pk(1'b0, 1'b0, 1'b0, last_x, last_y, last_c));
    abort = 1'b0;
    draw(1'b0, 9'd200, 9'd202, 8'd100, 8'd100, 3'd3, 1'b0, 1'b0, "reaccept");

    for (int n = 0; n < 40; n++) begin
      logic [8:0] a0, a1;
      logic [7:0] b0, b1;
      a0 = 9'($urandom_range(1, 325));
      a1 = a0 + 9'($urandom_range(0, 6)) - 9'd1;
      b0 = 8'($urandom_range(1, 245));
      b1 = b0 + 8'($urandom_range(0, 6)) - 8'd1;
      draw(1'($urandom_range(0, 1)), a0, a1, b0, b1, 3'($urandom_range(0, 7)),
           (n % 3) == 0, 1'b0, "rand");
    end

    // Reset in the middle of a draw, then a fresh draw from its origin.
    build(1'b0, 9'd0, 9'd9, 8'd0, 8'd9);
    mode = 1'b0; x0 = 9'd0; x1 = 9'd9; y0 = 8'd0; y1 = 8'd9; color_in = 3'd4;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rst_pix", obs(), pk(1'b1, 1'b1, 1'b0, ex_q[i], ey_q[i], 4));
      @(negedge clock);
    end
    #2 resetn = 1'b0;
    #1 chk("rst_mid", obs(), pk(1'b0, 1'b0, 1'b0, 0, 0, 0));
    last_x = 0; last_y = 0; last_c = 0;
    @(negedge clock);
    chk("rst_mid_hold", obs(), pk(1'b0, 1'b0, 1'b0, 0, 0, 0));
    resetn = 1'b1;
    draw(1'b0, 9'd3, 9'd4, 8'd7, 8'd8, 3'd6, 1'b0, 1'b0, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
